// File: rtl/data_serializer_pkg.sv
// Shared definitions for the wide-word to narrow-beat serializer:
// the FSM state encoding and the default word/beat widths.
package data_serializer_pkg;

  // IDLE: no word held. SEND: a word is held and beats are pending.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEFAULT_IN_WIDTH  = 1024;
  localparam int DEFAULT_OUT_WIDTH = 128;

endpackage : data_serializer_pkg

// File: rtl/data_serializer.sv
// data_serializer: holds one IN_WIDTH word and emits it as RATIO beats of
// OUT_WIDTH bits, LSB slice first, with valid/ready handshakes on both sides.
// The next word may load in the same cycle the last beat leaves, which gives
// one word every RATIO cycles with no bubble.
// Optional feature macro: DATA_SERIALIZER_PARITY_EN adds parity_out, the XOR
// reduction of data_out (0 whenever no beat is valid).
module data_serializer
  import data_serializer_pkg::*;
#(
  parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic                 last_out
`ifdef DATA_SERIALIZER_PARITY_EN
  ,
  output logic                 parity_out
`else
  // default build: no parity port
`endif
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = $clog2(RATIO);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IN_WIDTH-1:0] hold_q, hold_d;

  logic in_xfer;
  logic out_xfer;
  logic is_last;

  // Outputs depend only on registered state, never on the input side.
  assign valid_out = (state_q == SEND);
  assign is_last   = valid_out && (beat_q == LAST_BEAT);
  assign last_out  = is_last;
  // Gated so the output bus is quiet (and parity is 0) while idle.
  assign data_out  = valid_out ? hold_q[int'(beat_q) * OUT_WIDTH +: OUT_WIDTH]
                               : '0;
  assign ready_in  = (state_q == IDLE) || (is_last && ready_out);

  assign in_xfer  = valid_in && ready_in;
  assign out_xfer = valid_out && ready_out;

`ifdef DATA_SERIALIZER_PARITY_EN
  assign parity_out = ^data_out;
`else
  // parity logic is absent in the default build
`endif

  // Next-state logic: load on input transfer, advance on output transfer,
  // reload in place when the last beat leaves alongside a new word.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          hold_d  = data_in;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + BEAT_W'(1);
          end else if (in_xfer) begin
            hold_d  = data_in;
            beat_d  = '0;
            state_d = SEND;
          end else begin
            beat_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // State, beat index and hold register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
    end
  end

endmodule : data_serializer

// File: tb/tb_data_serializer.sv
// Self-checking bench for data_serializer (default 1024/128, eight beats).
// A queue-of-beats model predicts every output each cycle; directed phases
// add hand-computed expectations. Define DATA_SERIALIZER_PARITY_EN to also
// check parity_out.
module tb_data_serializer;

  localparam int IW = 1024;
  localparam int OW = 128;
  localparam int R  = IW / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] data_in;
  logic          valid_in;
  logic          ready_in;
  logic [OW-1:0] data_out;
  logic          valid_out;
  logic          ready_out;
  logic          last_out;
`ifdef DATA_SERIALIZER_PARITY_EN
  logic          parity_out;
`endif

  data_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .last_out  (last_out)
`ifdef DATA_SERIALIZER_PARITY_EN
    ,
    .parity_out(parity_out)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of pending beats ----------------
  typedef struct packed {
    logic [OW-1:0] d;
    logic          last;
  } beat_t;

  beat_t q[$];
  bit    model_on = 0;
  bit    pop_n = 0, push_n = 0;
  logic [IW-1:0] word_n;

  // Compare on the falling edge and decide what the coming rising edge does.
  always @(negedge clk) begin
    logic          e_v, e_l, e_ri;
    logic [OW-1:0] e_d;
    if (model_on) begin
      e_v  = (q.size() > 0);
      e_d  = e_v ? q[0].d : '0;
      e_l  = e_v ? q[0].last : 1'b0;
      e_ri = (q.size() == 0) || (q.size() == 1 && ready_out);
      check("m_valid_out", OW'(valid_out), OW'(e_v));
      check("m_data_out",  data_out,       e_d);
      check("m_last_out",  OW'(last_out),  OW'(e_l));
      check("m_ready_in",  OW'(ready_in),  OW'(e_ri));
`ifdef DATA_SERIALIZER_PARITY_EN
      check("m_parity_out", OW'(parity_out), OW'(^e_d));
`endif
      pop_n  = e_v && ready_out;
      push_n = valid_in && e_ri;
      word_n = data_in;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      model_on = 1;
      pop_n = 0;
      push_n = 0;
    end else if (model_on) begin
      if (pop_n) void'(q.pop_front());
      if (push_n) begin
        for (int k = 0; k < R; k++) begin
          beat_t b;
          b.d    = word_n[k*OW +: OW];
          b.last = (k == R - 1);
          q.push_back(b);
        end
      end
      pop_n = 0;
      push_n = 0;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [IW-1:0] rand_word();
    logic [IW-1:0] w;
    for (int i = 0; i < IW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [IW-1:0] nib_word();
    logic [IW-1:0] w;
    logic [3:0]    nib;
    for (int k = 0; k < R; k++) begin
      nib = 4'(k);
      w[k*OW +: OW] = {(OW/4){nib}};
    end
    return w;
  endfunction

  // Present a word until accepted; returns just after the accepting edge.
  task automatic send_word(input logic [IW-1:0] w);
    bit acc = 0;
    valid_in = 1'b1;
    data_in  = w;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    if (!acc) check("send_timeout", OW'(0), OW'(1));
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [IW-1:0] wa, wb, wn;
    logic [3:0]    nib;
    rst = 1'b1; valid_in = 1'b1; data_in = rand_word(); ready_out = 1'b1;

    // Reset held three cycles with valid_in asserted.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid_out", OW'(valid_out), OW'(0));
    check("rst_last_out",  OW'(last_out),  OW'(0));
    check("rst_ready_in",  OW'(ready_in),  OW'(1));
    check("rst_data_out",  data_out,       OW'(0));
    rst = 1'b0; valid_in = 1'b0;
    step();
    @(negedge clk);
    check("rst_no_accept", OW'(valid_out), OW'(0));
    step();

    // Single word of nibble-patterned slices.
    wn = nib_word();
    send_word(wn);
    for (int k = 0; k < R; k++) begin
      @(negedge clk);
      nib = 4'(k);
      check("single_data",  data_out,       {(OW/4){nib}});
      check("single_last",  OW'(last_out),  OW'(k == R - 1));
      check("single_valid", OW'(valid_out), OW'(1));
      step();
    end
    @(negedge clk);
    check("single_idle", OW'(valid_out), OW'(0));
    step();

    // Back-to-back words: 16 beats without a gap.
    wa = rand_word(); wb = rand_word();
    send_word(wa);
    valid_in = 1'b1; data_in = wb;
    for (int c = 0; c < 2 * R; c++) begin
      @(negedge clk);
      check("b2b_nogap", OW'(valid_out), OW'(1));
      check("b2b_data", data_out, (c < R) ? wa[c*OW +: OW] : wb[(c-R)*OW +: OW]);
      if (c == R - 1) check("b2b_accept_on_last", OW'(ready_in), OW'(1));
      step();
      if (c == R - 1) valid_in = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle", OW'(valid_out), OW'(0));
    step();

    // Backpressure at beat 3 for five cycles.
    wa = rand_word(); wb = rand_word();
    send_word(wa);
    repeat (3) step();
    ready_out = 1'b0; valid_in = 1'b1; data_in = wb;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_data",     data_out,       wa[3*OW +: OW]);
      check("bp_valid",    OW'(valid_out), OW'(1));
      check("bp_ready_in", OW'(ready_in),  OW'(0));
      step();
    end
    ready_out = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    check("bp_release", data_out, wa[3*OW +: OW]);
    step();
    @(negedge clk);
    check("bp_resume", data_out, wa[4*OW +: OW]);
    repeat (5) step();
    @(negedge clk);
    check("bp_idle", OW'(valid_out), OW'(0));
    step();

    // Reset in the middle of a word.
    wa = rand_word(); wb = rand_word();
    send_word(wa);
    repeat (5) step();
    @(negedge clk);
    check("rstmid_beat5", data_out, wa[5*OW +: OW]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_valid", OW'(valid_out), OW'(0));
    step();
    send_word(wb);
    @(negedge clk);
    check("rstmid_restart", data_out, wb[OW-1:0]);
    repeat (R + 1) step();

`ifdef DATA_SERIALIZER_PARITY_EN
    // Parity of beat values 0x1 and 0x3.
    wa = '0;
    wa[OW-1:0]    = OW'(1);
    wa[2*OW-1:OW] = OW'(3);
    send_word(wa);
    @(negedge clk);
    check("parity_one",   OW'(parity_out), OW'(1));
    step();
    @(negedge clk);
    check("parity_three", OW'(parity_out), OW'(0));
    repeat (R + 1) step();
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      data_in   = rand_word();
      ready_out = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    repeat (R + 4) step();
    @(negedge clk);
    check("final_idle", OW'(valid_out), OW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_data_serializer

// File: doc/data_serializer.md
DATA_SERIALIZER -- requirements
Module: data_serializer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 1024, giving the input word width in bits.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 128, giving the output beat width; IN_WIDTH SHALL be an integer multiple of OUT_WIDTH, with RATIO = IN_WIDTH/OUT_WIDTH >= 2.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data_in  input  IN_WIDTH  wide word from the upstream forwarding FIFO.
REQ-006 valid_in  input  1  data_in valid.
REQ-007 ready_in  output  1  block accepts data_in this cycle.
REQ-008 data_out  output  OUT_WIDTH  current beat.
REQ-009 valid_out  output  1  data_out valid.
REQ-010 ready_out  input  1  downstream accepts the beat.
REQ-011 last_out  output  1  high with the final beat (index RATIO-1) of a word.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE (no word held) and SEND (word held, beats pending).
REQ-013 A transfer SHALL occur on a port when valid and ready are both high at a rising edge.
REQ-014 In IDLE: ready_in=1, valid_out=0; an input transfer latches data_in into the hold register, sets beat index to 0, and moves to SEND.
REQ-015 In SEND: valid_out=1; data_out = hold[beat*OUT_WIDTH +: OUT_WIDTH], LSB slice first; last_out = (beat == RATIO-1).
REQ-016 An output transfer on a non-last beat SHALL increment beat by 1 and stay in SEND.
REQ-017 An output transfer on the last beat with no simultaneous input transfer SHALL return to IDLE.
REQ-018 ready_in SHALL be (state==IDLE) || (last_out && ready_out), so a new word can load in the same cycle the last beat leaves; that case SHALL reload hold, reset beat to 0, and stay in SEND (zero-bubble throughput: one word per RATIO cycles).
REQ-019 Latency: first beat of a word accepted at edge N SHALL be valid in the cycle after edge N (one cycle).
REQ-020 When ready_out=0 in SEND, data_out, last_out, beat and hold SHALL remain stable (AXI-style: valid_out never drops before transfer).
REQ-021 valid_out, data_out, last_out SHALL not combinationally depend on valid_in or data_in.
REQ-022 Beat index SHALL be $clog2(RATIO) bits wide and SHALL never exceed RATIO-1.

Reset
REQ-023 While rst=1 at a clock edge: state=IDLE, beat=0, hold=0; hence valid_out=0, last_out=0, data_out=0, ready_in=1 on the following cycle.
REQ-024 Reset asserted mid-word SHALL discard the held word; no further beats of it SHALL appear.

Configuration
REQ-025 Macro DATA_SERIALIZER_PARITY_EN, when defined, SHALL add output parity_out (1 bit) equal to the XOR reduction of data_out, valid whenever valid_out=1, 0 in reset/IDLE.
REQ-026 Without DATA_SERIALIZER_PARITY_EN the parity_out port and its logic SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package data_serializer_pkg SHALL hold the FSM state typedef (IDLE, SEND) and the default IN_WIDTH/OUT_WIDTH constants.
REQ-028 The block SHALL be a single module with no sub-module; the beat slice select is an indexed part-select of the hold register.

Verification
REQ-029 Reset: hold rst=1 for 3 cycles with valid_in=1 -> valid_out=0, last_out=0, ready_in=1, no word accepted.
REQ-030 Single word: data_in = beats 0x0..0,0x1..1,...,0x7..7 (slice k all nibbles k), ready_out=1 -> 8 beats in order slice 0..7 on consecutive cycles, last_out only on slice 7, then IDLE.
REQ-031 Back-to-back: two words presented continuously, ready_out=1 -> 16 consecutive beats with no valid_out gap; second word accepted on the cycle of first word's last beat.
REQ-032 Backpressure: ready_out=0 for 5 cycles at beat 3 -> data_out stays slice 3, valid_out stays 1, ready_in=0; resumes at beat 4 after release.
REQ-033 Reset mid-word: rst=1 during beat 5 -> next cycle valid_out=0; next word starts at slice 0.
REQ-034 With DATA_SERIALIZER_PARITY_EN: beat value 0x1 -> parity_out=1; beat value 0x3 -> parity_out=0.
